pci_rr_arbiter: RTL and testbench



---
 rtl/pci_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 31 +++
 rtl/pci_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_pci_rr_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the round-robin PCI bus arbiter and the device models around it.
package pci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } arb_state_e;

  localparam int LAT_TIMER_DEF   = 16;
  localparam int GNT_TIMEOUT_DEF = 8;

  // Bus control lines are active-low.
  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req searching upward from ptr+1, wrapping at N-1.
module rr_pick #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // i runs to N so ptr itself is the last candidate.
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/pci_rr_arbiter.sv
// Round-robin bus arbiter: hands the bus over only when idle, reclaims no-shows, preempts long owners.
//   state | meaning
//   IDLE  | no grant, waiting for any request
//   GRANT | grant issued, waiting for owner to start a frame
//   BUSY  | owner transferring; latency timer running
//   TURN  | one turnaround cycle with all grants high
module pci_rr_arbiter
  import pci_arb_pkg::*;
#(
  parameter int N           = 5,
  parameter int LAT_TIMER   = LAT_TIMER_DEF,
  parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         request,
  input  logic                 iframe,
  input  logic                 iready,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 owner_valid,
  output logic                 preempt
);

  localparam int IW = $clog2(N);
  localparam int CW = cnt_width(LAT_TIMER, GNT_TIMEOUT);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          preempt_q, preempt_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [CW-1:0] lat_q, lat_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [N-1:0]  own_oh;
  logic          bus_idle, held, others, withdrawn, lat_exp, gnt_exp;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (~request),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    own_oh          = '0;
    own_oh[owner_q] = 1'b1;
  end

  assign bus_idle  = (iframe == DEASSERTED) && (iready == DEASSERTED);
  assign held      = (grant_q != '1);
  assign others    = |(~request & ~own_oh);
  assign withdrawn = (request[owner_q] == DEASSERTED);
  assign lat_exp   = (lat_q == CW'(LAT_TIMER - 1));
  assign gnt_exp   = (idle_q == CW'(GNT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '1;
      owner_q   <= '0;
      ptr_q     <= IW'(N - 1);
      preempt_q <= 1'b0;
      idle_q    <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      preempt_q <= preempt_d;
      idle_q    <= idle_d;
      lat_q     <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = GRANT;
      GRANT: begin
        if (iframe == ASSERTED)        state_d = BUSY;
        else if (withdrawn || gnt_exp) state_d = TURN;
      end
      BUSY:    if (bus_idle) state_d = TURN;
      TURN:    state_d = pick_any ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
    // Counters sit at zero outside their state, so each entry starts fresh.
    idle_d = (state_q == GRANT) ? idle_q + CW'(1) : '0;
    if (state_q != BUSY)              lat_d = '0;
    else if (lat_q == CW'(LAT_TIMER)) lat_d = lat_q;
    else                              lat_d = lat_q + CW'(1);
  end

  always_comb begin
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        grant_d = '1;
        if (pick_any) begin
          grant_d[pick_idx] = ASSERTED;
          owner_d           = pick_idx;
          ptr_d             = pick_idx;
        end
      end
      GRANT: begin
        if (iframe != ASSERTED && (withdrawn || gnt_exp)) grant_d = '1;
      end
      BUSY: begin
        // Bus idle takes priority so a simultaneous expiry never pulses preempt.
        if (bus_idle) begin
          grant_d = '1;
        end else if (lat_exp && others && held) begin
          grant_d   = '1;
          preempt_d = 1'b1;
        end
      end
      default: grant_d = '1;
    endcase
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign owner_valid = held;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed bench for pci_rr_arbiter with hand-computed grant/owner/preempt expectations.
module tb_pci_rr_arbiter;
  import pci_arb_pkg::*;

  localparam int N = 5;

  logic         clk;
  logic         rst;
  logic [N-1:0] request;
  logic         iframe;
  logic         iready;
  logic [N-1:0] grant;
  logic [2:0]   owner;
  logic         owner_valid;
  logic         preempt;

  int total = 0;
  int bad   = 0;

  pci_rr_arbiter #(.N(N), .LAT_TIMER(16), .GNT_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .iframe      (iframe),
    .iready      (iready),
    .grant       (grant),
    .owner       (owner),
    .owner_valid (owner_valid),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    request = '1;
    iframe  = DEASSERTED;
    iready  = DEASSERTED;
    tick(2);
    rst = 1'b0;
  endtask

  logic [N-1:0] exp_g;
  logic [N-1:0] one;

  initial begin
    rst     = 1'b1;
    request = '1;
    iframe  = DEASSERTED;
    iready  = DEASSERTED;
    one     = 5'b00001;

    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant), 32'h1f);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_valid", 32'(owner_valid), 0);
    chk("rst_preempt", 32'(preempt), 0);

    // Single request
    request = 5'b11110;
    tick();
    chk("single_grant", 32'(grant), 32'h1e);
    chk("single_owner", 32'(owner), 0);
    chk("single_valid", 32'(owner_valid), 1);
    request = 5'b11111;
    tick(2);
    chk("single_release", 32'(grant), 32'h1f);
    chk("single_valid0", 32'(owner_valid), 0);

    // Fair rotation: 0,1,2,3,4,0 with a TURN cycle between each
    do_reset();
    request = 5'b00000;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_g = ~(one << (k % N));
      chk($sformatf("rot%0d_grant", k), 32'(grant), 32'(exp_g));
      chk($sformatf("rot%0d_owner", k), 32'(owner), k % N);
      if (k == 5) break;
      iframe = ASSERTED;
      tick(3);
      iframe = DEASSERTED;
      tick();
      chk($sformatf("rot%0d_turn", k), 32'(grant), 32'h1f);
      tick();
    end
    request = '1;
    tick(2);

    // No-show timeout: device 2 (with device 4 waiting) never starts a frame
    do_reset();
    request = 5'b01011;
    tick();
    chk("to_grant", 32'(grant), 32'h1b);
    tick(7);
    chk("to_held7", 32'(grant), 32'h1b);
    tick();
    chk("to_release", 32'(grant), 32'h1f);
    tick();
    chk("to_next", 32'(grant), 32'h0f);
    chk("to_next_owner", 32'(owner), 4);
    request = '1;
    tick(2);

    // Preemption: device 1 holds the bus 40 clk while device 3 waits
    do_reset();
    request = 5'b11101;
    tick();
    chk("pre_grant", 32'(grant), 32'h1d);
    iframe  = ASSERTED;
    request = 5'b10101;
    tick(16);
    chk("pre_held15", 32'(grant), 32'h1d);
    chk("pre_nopulse15", 32'(preempt), 0);
    tick();
    chk("pre_release", 32'(grant), 32'h1f);
    chk("pre_pulse", 32'(preempt), 1);
    tick();
    chk("pre_pulse_end", 32'(preempt), 0);
    chk("pre_no_early", 32'(grant), 32'h1f);
    tick(22);
    chk("pre_still_busy", 32'(grant), 32'h1f);
    iframe = DEASSERTED;
    tick();
    chk("pre_turn", 32'(grant), 32'h1f);
    tick();
    chk("pre_next", 32'(grant), 32'h17);
    chk("pre_next_owner", 32'(owner), 3);
    request = '1;
    tick(3);

    // Latency expiry coinciding with bus idle: no preempt pulse
    do_reset();
    request = 5'b11101;
    tick();
    iframe  = ASSERTED;
    request = 5'b10101;
    tick(16);
    iframe = DEASSERTED;
    tick();
    chk("coin_release", 32'(grant), 32'h1f);
    chk("coin_nopulse", 32'(preempt), 0);
    tick();
    chk("coin_next", 32'(grant), 32'h17);
    request = '1;
    tick(3);

    // Withdrawal race: iframe falls as request rises -> BUSY, grant held
    do_reset();
    request = 5'b11011;
    tick();
    iframe  = ASSERTED;
    request = 5'b11111;
    tick();
    chk("race_held", 32'(grant), 32'h1b);
    chk("race_valid", 32'(owner_valid), 1);
    tick();
    chk("race_busy", 32'(grant), 32'h1b);

    // Reset mid-BUSY, then arbitration restarts from device 0
    rst = 1'b1;
    tick();
    chk("mrst_grant", 32'(grant), 32'h1f);
    chk("mrst_valid", 32'(owner_valid), 0);
    chk("mrst_preempt", 32'(preempt), 0);
    rst     = 1'b0;
    iframe  = DEASSERTED;
    request = 5'b00000;
    tick();
    chk("mrst_first", 32'(grant), 32'h1e);
    chk("mrst_owner", 32'(owner), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
